// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default parameters for the round-robin arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEFAULT_N = 2;
  localparam int DEFAULT_MAX_HOLD = 4;
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating 2**N-to-N priority encoder searching downward from ptr; X-propagation under RR_ARB_XCHECK_EN
module rr_prio_enc
  import arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [2**N-1:0] req,
  input  logic [N-1:0]    ptr,
  input  logic            exclude_en,
  input  logic [N-1:0]    exclude_idx,
  output logic [N-1:0]    win_idx,
  output logic            any
);
  localparam int M = 2**N;
  logic [M-1:0] rot;
  logic [N-1:0] cand [M];
  logic [N-1:0] pick;
  genvar g;
  for (g = 0; g < M; g++) begin : g_rot
    assign cand[g] = ptr - N'(g);
    assign rot[g] = req[cand[g]] && !(exclude_en && cand[g] == exclude_idx);
  end
  // lowest rotated position wins, i.e. the first requester found scanning down from ptr
  always_comb begin
    pick = '0;
    for (int k = M - 1; k >= 0; k--) pick = rot[k] ? cand[k] : pick;
  end
  assign any = |rot;
`ifdef RR_ARB_XCHECK_EN
  assign win_idx = $isunknown(req) ? 'x : pick;
`else
  assign win_idx = pick;
`endif
endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: round-robin arbiter with registered grant and hold limit; RR_ARB_XCHECK_EN adds assertions
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2**N-1:0] req,
  output logic [2**N-1:0] grant,
  output logic [N-1:0]    grant_idx,
  output logic            grant_valid
);
  localparam int M = 2**N;
  localparam int HW = MAX_HOLD == 0 ? 1 : $clog2(MAX_HOLD + 1);
  state_t state, state_n;
  logic [N-1:0] ptr, ptr_n, idx_n, win_idx;
  logic [HW-1:0] hold_cnt, hold_n;
  logic any, at_lim, owner_req, take;
  // while granting, the owner is excluded so win_idx/any describe the other requesters only
  rr_prio_enc #(.N(N)) u_enc (
    .req(req),
    .ptr(ptr),
    .exclude_en(state == GRANT),
    .exclude_idx(grant_idx),
    .win_idx(win_idx),
    .any(any)
  );
  assign owner_req = req[grant_idx];
  assign at_lim = MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD);
  // next state: stay granting while the owner holds or anyone else is waiting
  always_comb begin
    state_n = state == IDLE ? (any ? GRANT : IDLE) : (owner_req || any ? GRANT : IDLE);
  end
  // new owner on idle start, owner release, or hold-limit expiry with others pending
  always_comb begin
    take = any && (state == IDLE || !owner_req || at_lim);
    idx_n = take ? win_idx : (state_n == GRANT ? grant_idx : '0);
    ptr_n = take ? win_idx - N'(1) : ptr;
    hold_n = (MAX_HOLD == 0 || state_n == IDLE) ? '0 : take ? HW'(1) : at_lim ? hold_cnt : hold_cnt + HW'(1);
  end
  // state, pointer, hold counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= N'(M - 1);
      hold_cnt <= '0;
      grant <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      grant <= state_n == GRANT ? M'(1) << idx_n : '0;
      grant_idx <= idx_n;
      grant_valid <= state_n == GRANT;
    end
  end
`ifdef RR_ARB_XCHECK_EN
  localparam int BOUND = (M - 1) * (MAX_HOLD > 1 ? MAX_HOLD : 1) + 1;
  a_req_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(req));
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_valid: assert property (@(posedge clk) disable iff (reset) grant_valid == |grant);
  a_idx: assert property (@(posedge clk) disable iff (reset) grant_valid ? grant == M'(1) << grant_idx : grant_idx == '0);
  if (MAX_HOLD != 0) begin : g_live
    genvar i;
    for (i = 0; i < M; i++) begin : g_req
      a_live: assert property (@(posedge clk) disable iff (reset)
        (req[i] && !grant[i]) |-> ##[1:BOUND] (grant[i] || !req[i]));
    end
  end
`endif
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: directed table-driven checks of the round-robin arbiter
module tb_rr_priority_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic grant_valid;
  int asserts = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
  } vec_t;

  rr_priority_arbiter #(.N(2), .MAX_HOLD(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [3:0] rq);
    reset = rst;
    req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] idx, input logic v);
    asserts++;
    if (grant !== g || grant_idx !== idx || grant_valid !== v) begin
      fails++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
               name, grant, grant_idx, grant_valid, g, idx, v);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [1:0] order[5];
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rq);
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx, tbl[i].v);
    end
    order = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b1111);
      check($sformatf("rot_c%0d", c), oh(order[c / 4]), order[c / 4], 1'b1);
    end
    step(1'b1, 4'b0000);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'b0100);
      check($sformatf("solo_c%0d", c), 4'b0100, 2'd2, 1'b1);
    end
    step(1'b0, 4'b0110);
    check("sat_rotate", 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b0110);
    check("sat_new_owner", 4'b0010, 2'd1, 1'b1);
    step(1'b1, 4'b0000);
    check("final_reset", 4'b0000, 2'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
